// File: rtl/voucher_scan_ctrl.sv
// Voucher redemption sequencer: drives the barcode scanner with timeout and
// retry, screens the returned ID against a small circular history of
// redeemed IDs and reports a single registered result per request.

// One history slot: stores a redeemed ID and flags a match against the
// ID currently under check.
module voucher_hist_entry #(
  parameter int ID_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [ID_W-1:0] wr_id,
  input  logic [ID_W-1:0] cmp_id,
  output logic            hit
);

  logic            vld;
  logic [ID_W-1:0] id;

  // Clear has priority so a clear coinciding with a write drops the write.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      vld <= 1'b0;
      id  <= '0;
    end else if (wr_en) begin
      vld <= 1'b1;
      id  <= wr_id;
    end
  end

  assign hit = vld && (id == cmp_id);

endmodule

module voucher_scan_ctrl #(
  parameter int ID_W        = 16,
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_RETRY   = 2,
  parameter int HIST_DEPTH  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            clear_hist,
  output logic            scan_start,
  input  logic            scan_done,
  input  logic [ID_W-1:0] voucher_id_in,
  output logic            busy,
  output logic            done,
  output logic            accepted,
  output logic [1:0]      err_code,
  output logic [ID_W-1:0] voucher_id_out
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_TMO  = 2'd1;
  localparam logic [1:0] ERR_ZERO = 2'd2;
  localparam logic [1:0] ERR_DUP  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [TMR_W-1:0] timer, timer_nx;
  logic [RTY_W-1:0] retry, retry_nx;
  logic [ID_W-1:0]  id_r, id_nx;
  logic [1:0]       err_r, err_nx;
  logic             hist_wr;
  logic [PTR_W-1:0] wr_ptr;

  logic            acc_nx;
  logic [1:0]      err_code_nx;
  logic [ID_W-1:0] vid_out_nx;

  logic [HIST_DEPTH-1:0] hit_vec;
  logic [HIST_DEPTH-1:0] wr_sel;

  logic tmo;
  assign tmo = (timer == TMR_W'(TIMEOUT_CYC - 1));

  // History slots, one per entry; the write goes to the slot at wr_ptr.
  for (genvar i = 0; i < HIST_DEPTH; i++) begin : g_hist
    assign wr_sel[i] = hist_wr && (wr_ptr == PTR_W'(i));
    voucher_hist_entry #(.ID_W(ID_W)) u_ent (
      .clk    (clk),
      .reset  (reset),
      .clr    (clear_hist),
      .wr_en  (wr_sel[i]),
      .wr_id  (id_r),
      .cmp_id (id_r),
      .hit    (hit_vec[i])
    );
  end

  // Next-state, datapath next values and next registered outputs.
  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    retry_nx    = retry;
    id_nx       = id_r;
    err_nx      = err_r;
    hist_wr     = 1'b0;
    acc_nx      = accepted;
    err_code_nx = err_code;
    vid_out_nx  = voucher_id_out;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          state_nx = S_START;
          retry_nx = '0;
        end
      end
      S_START: begin
        timer_nx = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        timer_nx = timer + TMR_W'(1);
        // A scan result in the last timeout cycle still counts.
        if (scan_done) begin
          id_nx    = voucher_id_in;
          state_nx = S_CHECK;
        end else if (tmo) begin
          if (retry < RTY_W'(MAX_RETRY)) begin
            retry_nx = retry + RTY_W'(1);
            state_nx = S_START;
          end else begin
            err_nx   = ERR_TMO;
            id_nx    = '0;
            state_nx = S_DONE;
          end
        end
      end
      S_CHECK: begin
        if (id_r == '0) begin
          err_nx = ERR_ZERO;
        end else if (|hit_vec) begin
          err_nx = ERR_DUP;
        end else begin
          err_nx  = ERR_OK;
          hist_wr = 1'b1;
        end
        state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    // Result outputs change only as DONE is entered and hold otherwise.
    if (state_nx == S_DONE) begin
      acc_nx      = (err_nx == ERR_OK);
      err_code_nx = err_nx;
      vid_out_nx  = id_nx;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      scan_start     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      accepted       <= 1'b0;
      err_code       <= '0;
      voucher_id_out <= '0;
    end else begin
      state          <= state_nx;
      scan_start     <= (state_nx == S_START);
      busy           <= (state_nx != S_IDLE);
      done           <= (state_nx == S_DONE);
      accepted       <= acc_nx;
      err_code       <= err_code_nx;
      voucher_id_out <= vid_out_nx;
    end
  end

  // Attempt timer, retry count, latched ID and pending error code.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
      retry <= '0;
      id_r  <= '0;
      err_r <= '0;
    end else begin
      timer <= timer_nx;
      retry <= retry_nx;
      id_r  <= id_nx;
      err_r <= err_nx;
    end
  end

  // Write pointer; wraps naturally since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset || clear_hist) begin
      wr_ptr <= '0;
    end else if (hist_wr) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

endmodule
